// File: rtl/grid_access_arbiter.sv
// Map grid RAM sequencer: loads the default map from ROM, then arbitrates
// round-robin read/write access to the single-port grid RAM among requesters.
//
// state   | meaning
// INIT_RD | present cell counter to the default-map ROM
// INIT_WR | write ROM data for the current cell into the grid RAM
// IDLE    | wait for reinit or a request, pick the next requester
// ACCESS  | grant cycle, RAM address/write presented
// RDATA   | capture RAM read data
// DONE    | acknowledge the requester (with err if out of range)
module grid_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GRID_W  = 20,
  parameter int GRID_H  = 15
) (
  input  logic                   clock_50,
  input  logic                   reset_n,
  input  logic                   reinit,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [5*NUM_REQ-1:0]   req_x,
  input  logic [5*NUM_REQ-1:0]   req_y,
  input  logic [3*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     ack,
  output logic [2:0]             rdata,
  output logic                   err,
  output logic                   init_done,
  output logic [8:0]             mem_addr,
  output logic [2:0]             mem_wdata,
  output logic                   mem_we,
  input  logic [2:0]             mem_rdata,
  output logic [8:0]             rom_addr,
  input  logic [2:0]             rom_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CELLS = GRID_W * GRID_H;

  typedef enum logic [2:0] {
    INIT_RD,
    INIT_WR,
    IDLE,
    ACCESS,
    RDATA,
    DONE
  } state_t;

  state_t             state;
  logic [8:0]         a;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   cur_idx;
  logic               cur_we;
  logic               cur_oor;
  logic [2:0]         wdata_q;

  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic [4:0]         sel_x;
  logic [4:0]         sel_y;
  logic [2:0]         sel_wdata;
  logic               sel_in_range;
  logic [8:0]         sel_addr;
  int                 scan_j;

  // Round-robin scan: first set request at or above the pointer, wrapping.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    scan_j    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_j = (int'(ptr) + k) % NUM_REQ;
      if (!sel_valid && req[scan_j]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(scan_j);
      end
    end
  end

  assign sel_x        = req_x[int'(sel_idx)*5 +: 5];
  assign sel_y        = req_y[int'(sel_idx)*5 +: 5];
  assign sel_wdata    = req_wdata[int'(sel_idx)*3 +: 3];
  assign sel_in_range = (sel_x < 5'(GRID_W)) && (sel_y < 5'(GRID_H));
  assign sel_addr     = ({4'd0, sel_y} * 9'(GRID_W)) + {4'd0, sel_x};

  // ROM data is only valid during INIT_WR, so it bypasses the write-data register.
  assign mem_wdata = (state == INIT_WR) ? rom_data : wdata_q;

  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      state     <= INIT_RD;
      a         <= '0;
      ptr       <= '0;
      cur_idx   <= '0;
      cur_we    <= 1'b0;
      cur_oor   <= 1'b0;
      wdata_q   <= '0;
      gnt       <= '0;
      ack       <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      init_done <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      rom_addr  <= '0;
    end else begin
      case (state)
        INIT_RD: begin
          mem_addr <= a;
          mem_we   <= 1'b1;
          state    <= INIT_WR;
        end
        INIT_WR: begin
          mem_we <= 1'b0;
          if (a == 9'(CELLS - 1)) begin
            init_done <= 1'b1;
            state     <= IDLE;
          end else begin
            a        <= a + 9'd1;
            rom_addr <= a + 9'd1;
            state    <= INIT_RD;
          end
        end
        IDLE: begin
          if (reinit) begin
            init_done <= 1'b0;
            a         <= '0;
            rom_addr  <= '0;
            state     <= INIT_RD;
          end else if (sel_valid) begin
            cur_idx <= sel_idx;
            cur_we  <= req_we[sel_idx];
            cur_oor <= !sel_in_range;
            wdata_q <= sel_wdata;
            ptr     <= IDX_W'((int'(sel_idx) + 1) % NUM_REQ);
            gnt     <= NUM_REQ'(1) << sel_idx;
            if (sel_in_range) begin
              mem_addr <= sel_addr;
              mem_we   <= req_we[sel_idx];
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          gnt    <= '0;
          mem_we <= 1'b0;
          if (cur_we || cur_oor) begin
            ack <= NUM_REQ'(1) << cur_idx;
            err <= cur_oor;
            if (cur_oor && !cur_we) rdata <= '0;
            state <= DONE;
          end else begin
            state <= RDATA;
          end
        end
        RDATA: begin
          rdata <= mem_rdata;
          ack   <= NUM_REQ'(1) << cur_idx;
          state <= DONE;
        end
        DONE: begin
          ack   <= '0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= INIT_RD;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_access_arbiter.sv
// Directed bench for grid_access_arbiter with behavioural ROM (cell a -> a mod 8)
// and grid RAM models, both with one-cycle read latency.
module tb_grid_access_arbiter;

  localparam int NUM_REQ = 4;

  logic         clock_50;
  logic         reset_n;
  logic         reinit;
  logic [3:0]   req;
  logic [3:0]   req_we;
  logic [19:0]  req_x;
  logic [19:0]  req_y;
  logic [11:0]  req_wdata;
  logic [3:0]   gnt;
  logic [3:0]   ack;
  logic [2:0]   rdata;
  logic         err;
  logic         init_done;
  logic [8:0]   mem_addr;
  logic [2:0]   mem_wdata;
  logic         mem_we;
  logic [2:0]   mem_rdata;
  logic [8:0]   rom_addr;
  logic [2:0]   rom_data;

  logic [2:0]   ram [0:511];

  int n_chk  = 0;
  int n_fail = 0;

  grid_access_arbiter #(.NUM_REQ(NUM_REQ), .GRID_W(20), .GRID_H(15)) dut (
    .clock_50 (clock_50),
    .reset_n  (reset_n),
    .reinit   (reinit),
    .req      (req),
    .req_we   (req_we),
    .req_x    (req_x),
    .req_y    (req_y),
    .req_wdata(req_wdata),
    .gnt      (gnt),
    .ack      (ack),
    .rdata    (rdata),
    .err      (err),
    .init_done(init_done),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  initial clock_50 = 1'b0;
  always #10 clock_50 = ~clock_50;

  always @(posedge clock_50) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
    rom_data  <= rom_addr[2:0];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int any_out();
    return int'(|{gnt, ack, rdata, err, init_done, mem_addr, mem_wdata, mem_we, rom_addr});
  endfunction

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Watches an init load; k is the cycle number of each sampled negedge.
  task automatic watch(input int start_k, input bit stop_at_done,
                       output int we_cnt, output int we_bad, output int done_k,
                       output int gnt_k, output int early);
    we_cnt = 0; we_bad = 0; done_k = 0; gnt_k = 0; early = 0;
    for (int k = start_k; k <= start_k + 700; k++) begin
      @(negedge clock_50);
      if (mem_we) begin
        if (int'(mem_addr) != we_cnt || int'(mem_wdata) != we_cnt % 8) we_bad++;
        we_cnt++;
      end
      if (init_done && done_k == 0) done_k = k;
      if ((gnt != 0 || ack != 0) && !init_done) early++;
      if (gnt != 0) begin
        gnt_k = k;
        break;
      end
      if (stop_at_done && done_k != 0) break;
    end
  endtask

  task automatic do_access(input int idx, input bit we, input int x, input int y,
                           input int wd, input bit in_rng, input int exp_addr,
                           input int exp_rd);
    @(negedge clock_50);
    req_we[idx]          = we;
    req_x[idx*5 +: 5]    = 5'(x);
    req_y[idx*5 +: 5]    = 5'(y);
    req_wdata[idx*3 +: 3] = 3'(wd);
    req[idx]             = 1'b1;
    @(negedge clock_50);
    chk("acc_gnt", int'(gnt), 1 << idx);
    chk("acc_mem_we", int'(mem_we), int'(we && in_rng));
    if (in_rng) chk("acc_mem_addr", int'(mem_addr), exp_addr);
    if (we && in_rng) chk("acc_mem_wdata", int'(mem_wdata), wd);
    if (!we && in_rng) begin
      @(negedge clock_50);
      chk("acc_ack_early", int'(ack), 0);
    end
    @(negedge clock_50);
    chk("acc_ack", int'(ack), 1 << idx);
    chk("acc_err", int'(err), int'(!in_rng));
    if (!we) chk("acc_rdata", int'(rdata), exp_rd);
    req[idx] = 1'b0;
    @(negedge clock_50);
  endtask

  initial begin
    int we_cnt, we_bad, done_k, gnt_k, early;
    int acks, exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};

    reset_n   = 1'b0;
    reinit    = 1'b0;
    req       = 4'b1111;
    req_we    = 4'b0000;
    req_x     = {5'd3, 5'd2, 5'd1, 5'd0};
    req_y     = '0;
    req_wdata = '0;

    repeat (3) @(negedge clock_50);
    chk("reset_outputs", any_out(), 0);
    reset_n = 1'b1;

    // Initial load with all requesters asserting throughout.
    watch(2, 1'b0, we_cnt, we_bad, done_k, gnt_k, early);
    chk("init_we_count", we_cnt, 300);
    chk("init_we_addr_data", we_bad, 0);
    chk("init_done_cycle", done_k, 601);
    chk("init_no_gnt", early, 0);
    chk("first_gnt_cycle", gnt_k, 602);
    chk("first_gnt_idx", idx_of(gnt), 0);

    // Round-robin order with all requests held; reads of (i,0) return i.
    acks = 0;
    for (int c = 0; c < 40 && acks < 5; c++) begin
      @(negedge clock_50);
      if (gnt != 0) chk("gnt_onehot", $countones(gnt), 1);
      if (ack != 0) begin
        chk("ack_onehot", $countones(ack), 1);
        chk("rr_order", idx_of(ack), exp_seq[acks]);
        chk("rr_rdata", int'(rdata), exp_seq[acks]);
        acks++;
        if (acks == 5) req = 4'b0000;
      end
    end
    chk("rr_acks", acks, 5);
    req = 4'b0000;
    @(negedge clock_50);

    // Write then read (3,2) from requester 1.
    do_access(1, 1'b1, 3, 2, 5, 1'b1, 43, 0);
    do_access(1, 1'b0, 3, 2, 0, 1'b1, 43, 5);

    // Out-of-range accesses.
    do_access(3, 1'b0, 20, 0, 0, 1'b0, 0, 0);
    do_access(0, 1'b1, 5, 15, 6, 1'b0, 0, 0);
    do_access(2, 1'b0, 5, 14, 0, 1'b1, 285, 285 % 8);

    // reinit in IDLE with req[2] pending: full reload, then req[2] served.
    @(negedge clock_50);
    reinit    = 1'b1;
    req_we[2] = 1'b0;
    req_x[10 +: 5] = 5'd3;
    req_y[10 +: 5] = 5'd2;
    req[2]    = 1'b1;
    @(negedge clock_50);
    reinit = 1'b0;
    chk("reinit_done_low", int'(init_done), 0);
    watch(2, 1'b0, we_cnt, we_bad, done_k, gnt_k, early);
    chk("reload_we_count", we_cnt, 300);
    chk("reload_we_addr_data", we_bad, 0);
    chk("reload_done_cycle", done_k, 601);
    chk("reload_no_gnt", early, 0);
    chk("reload_gnt_cycle", gnt_k, 602);
    chk("reload_gnt_idx", int'(gnt), 4);
    repeat (2) @(negedge clock_50);
    chk("reload_ack", int'(ack), 4);
    chk("reload_rdata", int'(rdata), 3);
    req[2] = 1'b0;
    @(negedge clock_50);

    // Reset during a read ACCESS cycle.
    @(negedge clock_50);
    req_we[0] = 1'b0;
    req_x[0 +: 5] = 5'd1;
    req_y[0 +: 5] = 5'd0;
    req[0] = 1'b1;
    @(negedge clock_50);
    chk("mid_gnt", int'(gnt), 1);
    reset_n = 1'b0;
    req     = 4'b0000;
    @(negedge clock_50);
    chk("mid_reset_outputs", any_out(), 0);
    @(negedge clock_50);
    chk("mid_reset_no_ack", int'(ack), 0);
    reset_n = 1'b1;
    watch(2, 1'b1, we_cnt, we_bad, done_k, gnt_k, early);
    chk("restart_we_count", we_cnt, 300);
    chk("restart_we_addr_data", we_bad, 0);
    chk("restart_done_cycle", done_k, 601);
    chk("restart_no_gnt", gnt_k, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_access_arbiter.md
Name: grid_access_arbiter

Overview:
- Sequences and shares the single-port map grid RAM (20x15 cells, 3-bit cell codes, 1-cycle read latency) among several game agents: pacman, ghosts and the renderer.
- After reset or a reinit request, copies the default map from a ROM into the RAM cell by cell.
- Then services read and write requests from NUM_REQ requesters with round-robin arbitration and a req/ack handshake.
- Sits between the game-logic FSMs and the grid RAM instance.

Parameters:
- NUM_REQ, 4: number of requester ports.
- GRID_W, 20: cells per row.
- GRID_H, 15: rows. Cell count is GRID_W*GRID_H = 300; addresses are 9 bits.

Ports:
- clock_50  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- reinit  in  1  one-cycle pulse: reload the default map (level restart).
- req  in  NUM_REQ  per-requester request level.
- req_we  in  NUM_REQ  per-requester: 1 = write, 0 = read.
- req_x  in  5*NUM_REQ  packed x coordinates; requester i uses bits [5i+4:5i].
- req_y  in  5*NUM_REQ  packed y coordinates, same packing.
- req_wdata  in  3*NUM_REQ  packed write data.
- gnt  out  NUM_REQ  one-hot, 1-cycle pulse in the memory-access cycle.
- ack  out  NUM_REQ  one-hot, 1-cycle completion pulse.
- rdata  out  3  read result, valid in the ack cycle of a read.
- err  out  1  pulses with ack when the coordinate was out of range.
- init_done  out  1  high once the map load is complete.
- mem_addr  out  9  grid RAM address.
- mem_wdata  out  3  grid RAM write data.
- mem_we  out  1  grid RAM write enable.
- mem_rdata  in  3  grid RAM read data, 1 cycle after address.
- rom_addr  out  9  default-map ROM address.
- rom_data  in  3  ROM data, 1 cycle after rom_addr.

Behaviour:
- Clocking and reset: clock_50 only. reset_n is synchronous, active-low.
- While reset_n = 0, all outputs are 0 and the state is INIT_RD with cell counter a = 0 and round-robin pointer = 0.
- Reset mid-operation: any in-flight access is abandoned with no ack, and init restarts from cell 0.
- Address: y*GRID_W + x, computed in 9 bits. In range means x < GRID_W and y < GRID_H.
- State INIT_RD: rom_addr = a; mem_we = 0.
- State INIT_WR: mem_addr = a, mem_wdata = rom_data, mem_we = 1. Then:
  - if a = 299: init_done <= 1 and go to IDLE;
  - else a <= a+1 and go to INIT_RD.
- Init timing: 2 cycles per cell, 600 cycles total. Cycle 1 is the first cycle with reset_n = 1; init_done is high from cycle 601.
- During INIT, req is ignored: no gnt, no ack.
- State IDLE:
  - if reinit: init_done <= 0, a <= 0, go to INIT_RD. reinit takes priority over pending requests.
  - reinit outside IDLE is ignored.
  - else if any req is set: pick the first set bit scanning from the pointer upward (wrapping), latch that requester's index, we, x, y and wdata, set pointer <= index+1 mod NUM_REQ, and go to ACCESS.
- State ACCESS (cycle T+1, where T is the IDLE sampling cycle):
  - gnt[i] = 1.
  - If in range: mem_addr = computed address; mem_we = latched we; mem_wdata = latched data.
  - If out of range: mem_we = 0.
  - Go to DONE for a write or an out-of-range access; go to RDATA for an in-range read.
- State RDATA (T+2): capture mem_rdata into rdata; go to DONE.
- State DONE: ack[i] = 1 for one cycle; err = 1 if out of range; go to IDLE.
- Out-of-range read: rdata = 0. Out-of-range write: dropped.
- Latency:
  - write: ack at T+2, throughput 3 cycles;
  - read: ack at T+3, throughput 4 cycles.
- Requester rules:
  - hold req and all command fields stable from assertion until the ack cycle;
  - drop req in the cycle after ack, which is the IDLE cycle;
  - if req is still high in that IDLE cycle, it is treated as a new request.
- rdata holds its last value between reads.
- mem_we is high only in INIT_WR and in in-range write ACCESS cycles.
- Simultaneous requests resolve by the pointer only. No requester waits more than NUM_REQ-1 other services.

Test Plan:
- Reset release with ROM returning a known pattern (cell a -> a mod 8) -> mem_we pulses 300 times with mem_addr 0..299 and matching data; init_done rises at cycle 601; a req held high throughout init gets no gnt before then.
- After init, requester 1 writes (x=3, y=2, data=5), then requester 1 reads (3,2) -> write: mem_addr = 43 and ack at T+2. Read: ack[1] at T+3 with rdata = 5.
- All 4 reqs held continuously after reset -> grant order 0, 1, 2, 3, 0; each gnt/ack one-hot; no requester is starved.
- Read of (20,0), then write to (5,15) -> no mem_we; reads return rdata = 0 with err = 1. Both accesses are acked.
- reinit pulsed in IDLE while req[2] is high -> init_done drops, a full 600-cycle reload runs, then req[2] is granted.
- reset_n low during a read's ACCESS cycle -> no ack; all outputs 0; init restarts from cell 0 after release.
